// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated circular transmit FIFO.
// Frame format (data bits, parity, stop bits) is fixed at elaboration; frames go out back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [ADDR_W:0]    PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]      wr_ptr;
  logic [ADDR_W:0]      rd_ptr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_wr;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] head_word;

  tx_state_t            state;
  tx_state_t            state_next;
  logic [CNT_W-1:0]     clk_cnt;
  logic [CNT_W-1:0]     clk_cnt_next;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_next;
  logic                 stop_idx;
  logic                 stop_idx_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 parity_bit;
  logic                 parity_next;
  logic                 serial_next;
  logic                 active_next;
  logic                 done_next;
  logic                 load_word;
  logic                 bit_end;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
    return (PARITY == 1) ? ~^word : ^word;
  endfunction

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign fifo_wr      = i_Tx_DV && !fifo_full;
  assign o_Tx_Ready   = !fifo_full;
  assign o_Fifo_Count = wr_ptr - rd_ptr;
  assign head_word    = mem[rd_ptr[ADDR_W-1:0]];
  assign bit_end      = (clk_cnt == CNT_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_Tx_Overflow <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      o_Tx_Overflow <= i_Tx_DV && fifo_full;
    end
  end

  // Storage is flushed by the pointers, so the array itself needs no reset.
  always_ff @(posedge i_Clock) begin
    if (fifo_wr) begin
      mem[wr_ptr[ADDR_W-1:0]] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_next;
      clk_cnt     <= clk_cnt_next;
      bit_idx     <= bit_idx_next;
      stop_idx    <= stop_idx_next;
      shift_reg   <= shift_next;
      parity_bit  <= parity_next;
      o_Tx_Serial <= serial_next;
      o_Tx_Active <= active_next;
      o_Tx_Done   <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    clk_cnt_next  = clk_cnt + CNT_ONE;
    bit_idx_next  = bit_idx;
    stop_idx_next = stop_idx;
    shift_next    = shift_reg;
    parity_next   = parity_bit;
    serial_next   = o_Tx_Serial;
    active_next   = o_Tx_Active;
    done_next     = 1'b0;
    load_word     = 1'b0;
    fifo_pop      = 1'b0;

    case (state)
      S_IDLE: begin
        clk_cnt_next = '0;
        serial_next  = 1'b1;
        active_next  = 1'b0;
        if (!fifo_empty) begin
          load_word = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          serial_next  = shift_reg[0];
          state_next   = S_DATA;
        end
      end

      // Shift register moves right so the next bit to send is always at [1].
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_idx == IDX_LAST) begin
            if (PARITY != 0) begin
              serial_next = parity_bit;
              state_next  = S_PARITY;
            end else begin
              serial_next   = 1'b1;
              stop_idx_next = 1'b0;
              state_next    = S_STOP;
            end
          end else begin
            bit_idx_next = bit_idx + IDX_ONE;
            shift_next   = shift_reg >> 1;
            serial_next  = shift_reg[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_next  = '0;
          serial_next   = 1'b1;
          stop_idx_next = 1'b0;
          state_next    = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (stop_idx == STOP_LAST) begin
            done_next = 1'b1;
            if (!fifo_empty) begin
              load_word = 1'b1;
            end else begin
              serial_next = 1'b1;
              active_next = 1'b0;
              state_next  = S_IDLE;
            end
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end

      default: begin
        clk_cnt_next = '0;
        serial_next  = 1'b1;
        active_next  = 1'b0;
        state_next   = S_IDLE;
      end
    endcase

    // Shared by IDLE and the final stop bit so back-to-back frames have no gap.
    if (load_word) begin
      fifo_pop     = 1'b1;
      shift_next   = head_word;
      parity_next  = calc_parity(head_word);
      serial_next  = 1'b0;
      active_next  = 1'b1;
      clk_cnt_next = '0;
      state_next   = S_START;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model plus directed frame patterns.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int DB    = 8;
  localparam int PAR   = 2;
  localparam int SB    = 1;
  localparam int FLEN  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_ovf;
  logic [2:0] fifo_count;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  logic       tx_dv2;
  logic [6:0] tx_byte2;
  logic       tx_ready2;
  logic       tx_ovf2;
  logic [2:0] fifo_count2;
  logic       tx_serial2;
  logic       tx_active2;
  logic       tx_done2;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(tx_ready), .o_Tx_Overflow(tx_ovf), .o_Fifo_Count(fifo_count),
    .o_Tx_Serial(tx_serial), .o_Tx_Active(tx_active), .o_Tx_Done(tx_done)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv2), .i_Tx_Byte(tx_byte2),
    .o_Tx_Ready(tx_ready2), .o_Tx_Overflow(tx_ovf2), .o_Fifo_Count(fifo_count2),
    .o_Tx_Serial(tx_serial2), .o_Tx_Active(tx_active2), .o_Tx_Done(tx_done2)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         m_busy;
  int         m_t;
  logic [7:0] m_word;
  bit         m_done;
  bit         m_ovf;

  int act_cnt;
  int done_cnt;
  int ovf_cnt;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit dv, input logic [7:0] b);
    tx_dv   = dv;
    tx_byte = b;
  endtask

  // Line level at frame bit position idx: start, data LSB first, optional parity, stops.
  function automatic int frame_bit(input logic [7:0] w, input int idx);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(w[i]);
    if (idx == 0) return 0;
    if (idx <= DB) return int'(w[idx-1]);
    if (PAR != 0 && idx == DB + 1) return (PAR == 2) ? (ones % 2) : (1 - ones % 2);
    return 1;
  endfunction

  task automatic clearCounters();
    act_cnt  = 0;
    done_cnt = 0;
    ovf_cnt  = 0;
  endtask

  // One clock: advance the reference model at the rising edge, compare at the falling edge.
  task automatic tick();
    bit full;
    bit nonempty;
    @(posedge clk);
    m_done = 1'b0;
    m_ovf  = 1'b0;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_t    = 0;
    end else begin
      full     = (mq.size() == DEPTH);
      nonempty = (mq.size() != 0);
      m_ovf    = tx_dv && full;
      if (m_busy) begin
        if (m_t == FLEN * CPB - 1) begin
          m_done = 1'b1;
          if (nonempty) begin
            m_word = mq.pop_front();
            m_t    = 0;
          end else begin
            m_busy = 1'b0;
          end
        end else begin
          m_t++;
        end
      end else if (nonempty) begin
        m_word = mq.pop_front();
        m_t    = 0;
        m_busy = 1'b1;
      end
      if (tx_dv && !full) mq.push_back(tx_byte);
    end
    @(negedge clk);
    checkOutput("serial", int'(tx_serial), m_busy ? frame_bit(m_word, m_t / CPB) : 1);
    checkOutput("active", int'(tx_active), int'(m_busy));
    checkOutput("done", int'(tx_done), int'(m_done));
    checkOutput("count", int'(fifo_count), mq.size());
    checkOutput("ready", int'(tx_ready), int'(mq.size() < DEPTH));
    checkOutput("overflow", int'(tx_ovf), int'(m_ovf));
    act_cnt  += int'(tx_active);
    done_cnt += int'(tx_done);
    ovf_cnt  += int'(tx_ovf);
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_active || fifo_count != 0) && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("drain_bound", int'(tx_active || fifo_count != 0), 0);
    tick();
  endtask

  initial begin
    logic [10:0] pat_a5;
    logic [10:0] pat_d7;
    int n;
    pat_a5 = 11'b1_0_10100101_0;
    pat_d7 = 11'b1_1_0_0000111_0;

    rst = 1'b1;
    tx_dv = 1'b0; tx_byte = '0; tx_dv2 = 1'b0; tx_byte2 = '0;
    m_busy = 1'b0; m_t = 0; m_word = '0;
    clearCounters();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single 8E1 frame of 0xA5 from idle
    clearCounters();
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'h00);
    for (int j = 0; j < FLEN * CPB; j++) begin
      tick();
      checkOutput("a5_line", int'(tx_serial), int'(pat_a5[j / CPB]));
    end
    repeat (16) tick();
    checkOutput("a5_active_cycles", act_cnt, FLEN * CPB);
    checkOutput("a5_done_pulses", done_cnt, 1);

    // Three back-to-back frames
    clearCounters();
    applyStimulus(1'b1, 8'h00); tick();
    applyStimulus(1'b1, 8'hFF); tick();
    applyStimulus(1'b1, 8'h55); tick();
    applyStimulus(1'b0, 8'h00);
    repeat (150) tick();
    checkOutput("b2b_active_cycles", act_cnt, 3 * FLEN * CPB);
    checkOutput("b2b_done_pulses", done_cnt, 3);

    // Six writes into a depth-4 FIFO: one popped, four queued, one dropped
    clearCounters();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'($urandom));
      tick();
      if (i == 4) checkOutput("ready_after_5th", int'(tx_ready), 0);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("count_after_drop", int'(fifo_count), DEPTH);
    checkOutput("overflow_pulses", ovf_cnt, 1);
    drain();
    checkOutput("depth_done_pulses", done_cnt, 5);

    // Randomized traffic against the reference model
    clearCounters();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, 8'($urandom));
      tick();
    end
    applyStimulus(1'b0, 8'h00);
    drain();

    // Reset in the middle of data bit 3 with two words queued
    applyStimulus(1'b1, 8'h11); tick();
    applyStimulus(1'b1, 8'h22); tick();
    applyStimulus(1'b1, 8'h33); tick();
    applyStimulus(1'b0, 8'h00);
    n = 0;
    while (!(m_busy && m_t == 4 * CPB + 1) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("queued_before_reset", int'(fifo_count), 2);
    checkOutput("line_low_before_reset", int'(tx_serial), 0);
    clearCounters();
    rst = 1'b1;
    #1;
    checkOutput("rst_line_async", int'(tx_serial), 1);
    checkOutput("rst_active_async", int'(tx_active), 0);
    checkOutput("rst_count_async", int'(fifo_count), 0);
    checkOutput("rst_ready_async", int'(tx_ready), 1);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    checkOutput("rst_no_done", done_cnt, 0);
    applyStimulus(1'b1, 8'h3C);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("first_count", int'(fifo_count), 1);
    checkOutput("first_line_high", int'(tx_serial), 1);
    tick();
    checkOutput("first_line_low", int'(tx_serial), 0);
    drain();

    // 7O2 frame of 0x07 on the second instance
    tx_dv2 = 1'b1;
    tx_byte2 = 7'h07;
    tick();
    tx_dv2 = 1'b0;
    checkOutput("d7_count", int'(fifo_count2), 1);
    checkOutput("d7_idle_line", int'(tx_serial2), 1);
    for (int t = 0; t < 11 * CPB; t++) begin
      tick();
      checkOutput("d7_line", int'(tx_serial2), int'(pat_d7[t / CPB]));
      checkOutput("d7_active", int'(tx_active2), 1);
      checkOutput("d7_done", int'(tx_done2), 0);
    end
    tick();
    checkOutput("d7_done_end", int'(tx_done2), 1);
    checkOutput("d7_active_end", int'(tx_active2), 0);
    checkOutput("d7_line_end", int'(tx_serial2), 1);
    tick();
    checkOutput("d7_done_clear", int'(tx_done2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO. Frame format is set at elaboration time: data width, parity mode and stop-bit count. Bytes are queued through a valid/ready write port, and frames are serialised back-to-back with no idle gap while the FIFO is non-empty. It sits between the accelerator's result/status logic and the board UART pin, replacing the fixed 8N1 transmitter.

## Interface
- CLKS_PER_BIT, 87: i_Clock cycles per serial bit; must be ≥ 2.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; power of 2, ≥ 2.

Ports:
- i_Clock  in  1  single clock; all logic on its rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  write strobe; the word is accepted on a rising edge where i_Tx_DV && o_Tx_Ready.
- i_Tx_Byte  in  DATA_BITS  word to queue.
- o_Tx_Ready  out  1  FIFO not full; combinational from the count.
- o_Tx_Overflow  out  1  one-cycle pulse, registered; a write was attempted while full and was dropped.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  words queued, excluding the frame currently on the line.
- o_Tx_Serial  out  1  serial line; idles high.
- o_Tx_Active  out  1  a frame is being shifted.
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame.

## Operation
- Reset (async assert, sync release) sets: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Overflow=0, o_Fifo_Count=0, o_Tx_Ready=1, FSM=IDLE. The FIFO is flushed.
- A reset during a frame aborts it. The line goes high asynchronously, and no Done pulse is produced.
- FIFO: circular buffer with read/write pointers one bit wider than the address. Full and empty are decoded from the pointers.
- A write while full is dropped, even if a pop occurs on the same edge. It pulses o_Tx_Overflow for one cycle.
- A simultaneous write and pop with count > 0 leaves the count unchanged.
- Pop happens only on an edge where the FIFO is non-empty at that edge. A word written into an empty FIFO is never popped on its own write edge.
- FSM states:
  - IDLE: line high. If the FIFO is non-empty, pop the word into the shift register, compute parity, drive the line low, set Active, and go to START.
  - START: line low for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: bit index 0..DATA_BITS-1, each bit held for CLKS_PER_BIT cycles. After the last bit, go to PARITY if PARITY≠0, otherwise go to STOP.
  - PARITY: even parity bit = ^data; odd parity bit = ~^data. Held for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: line high for STOP_BITS×CLKS_PER_BIT cycles. On the final edge of the last stop bit:
    - Pulse Done.
    - If the FIFO is non-empty: pop, drive the line low, and go to START. Active stays high.
    - Otherwise: go to IDLE and clear Active.
- Bit counter width is $clog2(CLKS_PER_BIT). It resets to 0 on every bit transition and wraps at CLKS_PER_BIT-1.
- Illegal FSM encodings return to IDLE with the line high.

## Timing
- First-word latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE gives count=1 after N. The line goes low at edge N+1.
- Frame length is F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits, i.e. exactly F×CLKS_PER_BIT cycles from the line falling to the end of the last stop bit.
- o_Tx_Done is high for exactly one cycle, starting at the edge that ends the last stop bit. It coincides with the next start bit when frames are back-to-back.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- o_Tx_Active rises on the edge leaving IDLE and falls on the edge entering IDLE.

## Test plan
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1. Write 0xA5 when idle:
  - Line low 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Parity bit 0.
  - Stop bit high 4 cycles.
  - Done pulses once, 44 cycles after the line falls. Active is high for 44 cycles.
- Same configuration. Write 0x00, 0xFF, 0x55 on consecutive cycles:
  - Three contiguous frames with parity bits 0, 0, 0.
  - Done pulses 44 cycles apart.
  - Active continuously high for 132 cycles. The line is never high between a stop bit and the next start bit.
- FIFO_DEPTH=4. Write 6 words on 6 consecutive cycles starting from idle:
  - Words 1–5 are accepted; word 1 is popped at the second edge.
  - Ready goes low after the 5th write.
  - The 6th write is dropped with a single Overflow pulse; count stays 4.
  - Five frames are sent in order.
- DATA_BITS=7, PARITY=1, STOP_BITS=2. Write 0x07:
  - Data bits 1,1,1,0,0,0,0, then parity bit 0, then 2 stop bits.
  - Frame length 11×CLKS_PER_BIT.
- Assert i_Reset mid-way through data bit 3 of a frame, with 2 words queued:
  - Line goes high immediately, without waiting for a clock edge.
  - Count=0, Active=0, and no Done pulse.
  - After release, a new write 0x3C is transmitted correctly with first-word latency 1.
